// File: rtl/furv_bus_arbiter_if.sv
// furv_bus_arbiter_if
//   Bundles the fetch requester, load/store requester and downstream memory
//   port signals that meet at the furv bus arbiter.
//   modport master : the arbiter's view. It serves both requesters and drives
//                    the shared memory port.
//   modport slave  : the environment's view. This covers the requesters and
//                    the memory.
//   Fetch side : i_req, i_addr -> ; <- i_rdata, i_ack, i_err
//   Data side  : d_req, d_we, d_addr, d_sel, d_wdata -> ; <- d_rdata, d_ack, d_err
//   Memory side: <- mem, mem_write, addr, sel, data_out ; data_in, ack ->
interface furv_bus_arbiter_if;
  logic        i_req;
  logic [29:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        i_err;

  logic        d_req;
  logic        d_we;
  logic [29:0] d_addr;
  logic [3:0]  d_sel;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        d_err;

  logic        mem;
  logic        mem_write;
  logic [29:0] addr;
  logic [3:0]  sel;
  logic [31:0] data_out;
  logic [31:0] data_in;
  logic        ack;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_sel, d_wdata, data_in, ack,
    output i_rdata, i_ack, i_err, d_rdata, d_ack, d_err,
           mem, mem_write, addr, sel, data_out
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_sel, d_wdata, data_in, ack,
    input  i_rdata, i_ack, i_err, d_rdata, d_ack, d_err,
           mem, mem_write, addr, sel, data_out
  );
endinterface

// File: rtl/furv_bus_arbiter.sv
// furv_bus_arbiter
//   Shares the single furv memory port between instruction fetch (i_*) and
//   load/store (d_*). The arbiter allows one outstanding transaction at a time.
//   Under contention it alternates between the two requesters (round-robin).
//   It registers the downstream request. The ack and err results go back only
//   to the requester that holds the grant. An optional bus timeout aborts a
//   transaction that never receives an ack.
//   Parameter TIMEOUT: cycles of granted mem without ack before abort.
//                      A value of 0 disables the timeout.
//   Ports: clk, rst (synchronous, active high), bus (furv_bus_arbiter_if.master)
//
//   state  | meaning
//   IDLE   | no transaction; mem low; arbitrate on pending requests
//   BUSY_I | fetch transaction on the memory port
//   BUSY_D | load/store transaction on the memory port
module furv_bus_arbiter #(
  parameter int TIMEOUT = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  furv_bus_arbiter_if.master    bus
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TERM = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t          state;
  logic            last_d;     // 1: the most recent grant went to the data side
  logic [CW-1:0]   cnt;
  logic            mem_q;
  logic            mem_write_q;
  logic [29:0]     addr_q;
  logic [3:0]      sel_q;
  logic [31:0]     data_out_q;
  logic            term;
  logic            grant_i;

  // Terminal count only matters without ack, because an ack on the same cycle wins.
  assign term    = (TIMEOUT > 0) && !bus.ack && (cnt == TERM);
  // Fetch wins when it is alone, or when both request and data had the last turn.
  assign grant_i = bus.i_req && (!bus.d_req || last_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_d      <= 1'b1;
      cnt         <= '0;
      mem_q       <= 1'b0;
      mem_write_q <= 1'b0;
      addr_q      <= '0;
      sel_q       <= '0;
      data_out_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_i) begin
            state       <= BUSY_I;
            last_d      <= 1'b0;
            cnt         <= '0;
            mem_q       <= 1'b1;
            mem_write_q <= 1'b0;
            addr_q      <= bus.i_addr;
            sel_q       <= 4'b1111;
            data_out_q  <= '0;
          end else if (bus.d_req) begin
            state       <= BUSY_D;
            last_d      <= 1'b1;
            cnt         <= '0;
            mem_q       <= 1'b1;
            mem_write_q <= bus.d_we;
            addr_q      <= bus.d_addr;
            sel_q       <= bus.d_sel;
            data_out_q  <= bus.d_wdata;
          end
        end
        BUSY_I, BUSY_D: begin
          if (bus.ack || term) begin
            state <= IDLE;
            mem_q <= 1'b0;
          end else if (TIMEOUT > 0) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          mem_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem       = mem_q;
  assign bus.mem_write = mem_write_q;
  assign bus.addr      = addr_q;
  assign bus.sel       = sel_q;
  assign bus.data_out  = data_out_q;

  assign bus.i_rdata = bus.data_in;
  assign bus.d_rdata = bus.data_in;
  assign bus.i_ack   = (state == BUSY_I) && bus.ack;
  assign bus.d_ack   = (state == BUSY_D) && bus.ack;
  assign bus.i_err   = (state == BUSY_I) && term;
  assign bus.d_err   = (state == BUSY_D) && term;

endmodule

// File: tb/tb_furv_bus_arbiter.sv
module tb_furv_bus_arbiter;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   errs;

  furv_bus_arbiter_if b8 ();
  furv_bus_arbiter_if b4 ();
  furv_bus_arbiter_if b0 ();

  furv_bus_arbiter #(.TIMEOUT(8)) u8 (.clk(clk), .rst(rst), .bus(b8));
  furv_bus_arbiter #(.TIMEOUT(4)) u4 (.clk(clk), .rst(rst), .bus(b4));
  furv_bus_arbiter #(.TIMEOUT(0)) u0 (.clk(clk), .rst(rst), .bus(b0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    errs  = 0;
    rst   = 1'b1;
    b8.i_req = 0; b8.i_addr = '0; b8.d_req = 0; b8.d_we = 0; b8.d_addr = '0;
    b8.d_sel = '0; b8.d_wdata = '0; b8.data_in = '0; b8.ack = 0;
    b4.i_req = 0; b4.i_addr = '0; b4.d_req = 0; b4.d_we = 0; b4.d_addr = '0;
    b4.d_sel = '0; b4.d_wdata = '0; b4.data_in = '0; b4.ack = 0;
    b0.i_req = 0; b0.i_addr = '0; b0.d_req = 0; b0.d_we = 0; b0.d_addr = '0;
    b0.d_sel = '0; b0.d_wdata = '0; b0.data_in = '0; b0.ack = 0;

    cyc();
    cyc();
    #1;
    chk("rst_mem", b8.mem, 0);
    chk("rst_mem_write", b8.mem_write, 0);
    chk("rst_addr", b8.addr, 0);
    chk("rst_sel", b8.sel, 0);
    chk("rst_data_out", b8.data_out, 0);
    chk("rst_i_ack", b8.i_ack, 0);
    chk("rst_d_ack", b8.d_ack, 0);
    chk("rst_d_err", b8.d_err, 0);
    rst = 1'b0;

    // fetch only: ack two cycles after mem rises
    b8.i_req = 1; b8.i_addr = 30'h10;
    cyc(); #1;
    chk("f_mem", b8.mem, 1);
    chk("f_addr", b8.addr, 32'h10);
    chk("f_sel", b8.sel, 4'b1111);
    chk("f_we", b8.mem_write, 0);
    chk("f_ack_early", b8.i_ack, 0);
    cyc(); #1;
    chk("f_mem2", b8.mem, 1);
    chk("f_ack_early2", b8.i_ack, 0);
    cyc();
    b8.ack = 1; b8.data_in = 32'hDEADBEEF;
    #1;
    chk("f_i_ack", b8.i_ack, 1);
    chk("f_i_rdata", b8.i_rdata, 32'hDEADBEEF);
    chk("f_d_ack", b8.d_ack, 0);
    chk("f_i_err", b8.i_err, 0);
    cyc();
    b8.ack = 0; b8.i_req = 0;
    #1;
    chk("f_mem_off", b8.mem, 0);
    chk("f_ack_once", b8.i_ack, 0);

    // contention right after reset: order I, D, I, D with an idle cycle between
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    b8.i_req = 1; b8.i_addr = 30'h20;
    b8.d_req = 1; b8.d_addr = 30'h40; b8.d_we = 0; b8.d_sel = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      cyc(); #1;
      chk("c_mem", b8.mem, 1);
      chk("c_addr", b8.addr, (k % 2 == 0) ? 32'h20 : 32'h40);
      chk("c_no_ack", {b8.i_ack, b8.d_ack}, 0);
      cyc();
      b8.ack = 1; b8.data_in = 32'h1000 + k;
      #1;
      chk("c_i_ack", b8.i_ack, (k % 2 == 0) ? 1 : 0);
      chk("c_d_ack", b8.d_ack, (k % 2 == 1) ? 1 : 0);
      cyc();
      b8.ack = 0;
      if (k == 3) begin
        b8.i_req = 0; b8.d_req = 0;
      end
      #1;
      chk("c_idle", b8.mem, 0);
      chk("c_idle_ack", {b8.i_ack, b8.d_ack}, 0);
    end

    // store held stable while waiting for a slow ack
    b8.d_req = 1; b8.d_we = 1; b8.d_addr = 30'h100; b8.d_sel = 4'b0011;
    b8.d_wdata = 32'h0000ABCD;
    for (int k = 0; k < 5; k++) begin
      cyc(); #1;
      chk("s_mem", b8.mem, 1);
      chk("s_we", b8.mem_write, 1);
      chk("s_addr", b8.addr, 32'h100);
      chk("s_sel", b8.sel, 4'b0011);
      chk("s_data", b8.data_out, 32'h0000ABCD);
      chk("s_no_ack", b8.d_ack, 0);
    end
    cyc();
    b8.ack = 1;
    #1;
    chk("s_d_ack", b8.d_ack, 1);
    chk("s_i_ack", b8.i_ack, 0);
    chk("s_data_last", b8.data_out, 32'h0000ABCD);
    cyc();
    b8.ack = 0; b8.d_req = 0; b8.d_we = 0;
    #1;
    chk("s_mem_off", b8.mem, 0);
    chk("s_ack_once", b8.d_ack, 0);

    // stray ack while idle
    b8.ack = 1;
    #1;
    chk("stray_ack", {b8.i_ack, b8.d_ack}, 0);
    cyc(); #1;
    chk("stray_mem", b8.mem, 0);
    b8.ack = 0;

    // timeout of 8 on a load, then the pending fetch goes through
    b8.d_req = 1; b8.d_addr = 30'h200; b8.d_sel = 4'b1111;
    cyc();
    b8.i_req = 1; b8.i_addr = 30'h30;
    #1;
    chk("t_mem", b8.mem, 1);
    for (int k = 2; k <= 7; k++) begin
      cyc(); #1;
      chk("t_no_err", b8.d_err, 0);
    end
    cyc(); #1;
    chk("t_d_err", b8.d_err, 1);
    chk("t_d_ack", b8.d_ack, 0);
    chk("t_i_err", b8.i_err, 0);
    b8.d_req = 0;
    cyc(); #1;
    chk("t_mem_off", b8.mem, 0);
    chk("t_err_once", b8.d_err, 0);
    cyc(); #1;
    chk("t_i_grant", b8.mem, 1);
    chk("t_i_addr", b8.addr, 32'h30);
    cyc();
    b8.ack = 1;
    #1;
    chk("t_i_ack", b8.i_ack, 1);
    cyc();
    b8.ack = 0; b8.i_req = 0;

    // reset in the middle of a load; late ack must be ignored
    b8.d_req = 1; b8.d_addr = 30'h300;
    cyc(); #1;
    chk("r_mem", b8.mem, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0; b8.d_req = 0;
    #1;
    chk("r_mem_off", b8.mem, 0);
    cyc();
    b8.ack = 1;
    #1;
    chk("r_late_ack", {b8.d_ack, b8.d_err, b8.i_ack}, 0);
    cyc();
    b8.ack = 0; b8.i_req = 1; b8.i_addr = 30'h44;
    #1;
    chk("r_still_idle", b8.mem, 0);
    cyc(); #1;
    chk("r_i_grant", b8.mem, 1);
    chk("r_i_addr", b8.addr, 32'h44);
    cyc();
    b8.ack = 1;
    #1;
    chk("r_i_ack", b8.i_ack, 1);
    cyc();
    b8.ack = 0; b8.i_req = 0;

    // TIMEOUT=4: ack on the terminal-count cycle wins over err
    b4.d_req = 1; b4.d_addr = 30'h55; b4.d_sel = 4'b1111;
    for (int k = 1; k <= 3; k++) begin
      cyc(); #1;
      chk("t4_busy", {b4.mem, b4.d_ack, b4.d_err}, 3'b100);
    end
    cyc();
    b4.ack = 1;
    #1;
    chk("t4_d_ack", b4.d_ack, 1);
    chk("t4_d_err", b4.d_err, 0);
    cyc();
    b4.ack = 0; b4.d_req = 0;
    #1;
    chk("t4_mem_off", b4.mem, 0);
    chk("t4_no_err", b4.d_err, 0);

    // TIMEOUT=0: waits well beyond 256 cycles without err
    b0.i_req = 1; b0.i_addr = 30'h66;
    for (int k = 0; k < 300; k++) begin
      cyc(); #1;
      if (b0.i_err !== 1'b0 || b0.mem !== 1'b1) errs++;
    end
    chk("t0_no_err", errs, 0);
    chk("t0_mem_held", b0.mem, 1);
    cyc();
    b0.ack = 1;
    #1;
    chk("t0_i_ack", b0.i_ack, 1);
    cyc();
    b0.ack = 0; b0.i_req = 0;
    #1;
    chk("t0_mem_off", b0.mem, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
